fsm_semaforo: RTL and testbench

//   Two-street traffic-light controller (street A = index 0, street B = index 1).

---
 rtl/fsm_semaforo_pkg.sv | 32 +++
 rtl/semaforo_timer.sv | 18 +
 rtl/fsm_semaforo.sv | 100 ++++++++++
 tb/tb_fsm_semaforo.sv | 139 +++++++++++++
 4 files changed

// File: rtl/fsm_semaforo_pkg.sv
// Shared types and lamp patterns for the two-street traffic-light controller.
// Street A is bit 0 of every lamp vector, street B is bit 1.
package fsm_semaforo_pkg;

   typedef enum logic [2:0] {
      A_GREEN  = 3'd0,
      A_YELLOW = 3'd1,
      B_GREEN  = 3'd2,
      B_YELLOW = 3'd3,
      EMERG    = 3'd4
   } state_t;

   localparam int ST_A = 0;
   localparam int ST_B = 1;

   typedef struct packed {
      logic [1:0] verde;
      logic [1:0] amarillo;
      logic [1:0] rojo;
   } lamps_t;

   localparam lamps_t LAMP_A_GREEN  = '{verde: 2'b01, amarillo: 2'b00, rojo: 2'b10};
   localparam lamps_t LAMP_A_YELLOW = '{verde: 2'b00, amarillo: 2'b01, rojo: 2'b10};
   localparam lamps_t LAMP_B_GREEN  = '{verde: 2'b10, amarillo: 2'b00, rojo: 2'b01};
   localparam lamps_t LAMP_B_YELLOW = '{verde: 2'b00, amarillo: 2'b10, rojo: 2'b01};
   localparam lamps_t LAMP_EMERG    = '{verde: 2'b00, amarillo: 2'b00, rojo: 2'b11};

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/semaforo_timer.sv
// Saturating up-counter with synchronous clear; counts clocks spent in a state.
module semaforo_timer #(
   parameter int         W   = 2,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr)
         count <= '0;
      else if (count != MAX)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/fsm_semaforo.sv
// Moore traffic-light controller for two streets with emergency all-red override.
// Lamps are decoded purely from the state register.
module fsm_semaforo
   import fsm_semaforo_pkg::*;
#(
   parameter int YELLOW_CYCLES = 2,
   parameter int MIN_GREEN     = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       TA,
   input  logic       TB,
   input  logic       E,
   input  logic       R,
   output logic [1:0] verde,
   output logic [1:0] amarillo,
   output logic [1:0] rojo
);

   localparam int TMAX = max_int(YELLOW_CYCLES, MIN_GREEN);
   localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

   localparam logic [TW-1:0] TIMER_MAX = TW'(TMAX);
   localparam logic [TW-1:0] GREEN_MIN = TW'(MIN_GREEN - 1);
   localparam logic [TW-1:0] YEL_LAST  = TW'(YELLOW_CYCLES - 1);

   state_t        state;
   state_t        state_nx;
   logic [TW-1:0] timer;
   logic          timer_clr;
   lamps_t        lamps;

   always_ff @(posedge clk) begin
      if (!reset)
         state <= A_GREEN;
      else
         state <= state_nx;
   end

   // Timer restarts whenever the state is about to change, so it reads 0 on entry.
   assign timer_clr = !reset || (state_nx != state);

   semaforo_timer #(
      .W   (TW),
      .MAX (TIMER_MAX)
   ) u_timer (
      .clk   (clk),
      .clr   (timer_clr),
      .count (timer)
   );

   always_comb begin
      state_nx = A_GREEN;
      unique case (state)
         A_GREEN: begin
            if (E)                             state_nx = EMERG;
            else if (timer >= GREEN_MIN && !TA) state_nx = A_YELLOW;
            else                               state_nx = A_GREEN;
         end
         A_YELLOW: begin
            if (E)                      state_nx = EMERG;
            else if (timer >= YEL_LAST) state_nx = B_GREEN;
            else                        state_nx = A_YELLOW;
         end
         B_GREEN: begin
            if (E)                             state_nx = EMERG;
            else if (timer >= GREEN_MIN && !TB) state_nx = B_YELLOW;
            else                               state_nx = B_GREEN;
         end
         B_YELLOW: begin
            if (E)                      state_nx = EMERG;
            else if (timer >= YEL_LAST) state_nx = A_GREEN;
            else                        state_nx = B_YELLOW;
         end
         EMERG: begin
            if (!E && R) state_nx = A_GREEN;
            else         state_nx = EMERG;
         end
         default: state_nx = A_GREEN;
      endcase
   end

   // Unknown encodings show all-red until the next edge recovers to A_GREEN.
   always_comb begin
      lamps = LAMP_EMERG;
      unique case (state)
         A_GREEN:  lamps = LAMP_A_GREEN;
         A_YELLOW: lamps = LAMP_A_YELLOW;
         B_GREEN:  lamps = LAMP_B_GREEN;
         B_YELLOW: lamps = LAMP_B_YELLOW;
         EMERG:    lamps = LAMP_EMERG;
         default:  lamps = LAMP_EMERG;
      endcase
   end

   assign verde    = lamps.verde;
   assign amarillo = lamps.amarillo;
   assign rojo     = lamps.rojo;

endmodule

// File: tb/tb_fsm_semaforo.sv
// Bench for fsm_semaforo: directed scenarios then random traffic, compared against
// a right-of-way model that reasons about streets rather than states.
module tb_fsm_semaforo;

   localparam int YC = 2;
   localparam int MG = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       TA = 1'b0, TB = 1'b0, E = 1'b0, R = 1'b0;
   logic [1:0] verde, amarillo, rojo;

   int total = 0;
   int bad   = 0;

   // Reference model: who owns the intersection, whether they are clearing, emergency.
   int owner  = 0;
   bit yel    = 1'b0;
   bit emerg  = 1'b0;
   int dwell  = 0;
   logic [5:0] exp_q[$];

   fsm_semaforo #(.YELLOW_CYCLES(YC), .MIN_GREEN(MG)) dut (
      .clk      (clk),
      .reset    (reset),
      .TA       (TA),
      .TB       (TB),
      .E        (E),
      .R        (R),
      .verde    (verde),
      .amarillo (amarillo),
      .rojo     (rojo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [5:0] model_lamps();
      logic [1:0] v, a, r;
      v = 2'b00; a = 2'b00; r = 2'b11;
      if (!emerg) begin
         r[owner] = 1'b0;
         if (yel) a[owner] = 1'b1;
         else     v[owner] = 1'b1;
      end
      return {v, a, r};
   endfunction

   task automatic model_edge(input bit rst, input bit ta, input bit tb, input bit e, input bit r);
      bit sensor;
      if (!rst) begin
         emerg = 0; owner = 0; yel = 0; dwell = 0;
      end else if (emerg) begin
         if (!e && r) begin emerg = 0; owner = 0; yel = 0; dwell = 0; end
         else dwell++;
      end else if (e) begin
         emerg = 1; dwell = 0;
      end else if (yel) begin
         if (dwell + 1 >= YC) begin owner = 1 - owner; yel = 0; dwell = 0; end
         else dwell++;
      end else begin
         sensor = (owner == 0) ? ta : tb;
         if (dwell + 1 >= MG && !sensor) begin yel = 1; dwell = 0; end
         else dwell++;
      end
      exp_q.push_back(model_lamps());
   endtask

   task automatic step(input string tag, input bit rst, input bit ta, input bit tb,
                       input bit e, input bit r);
      logic [5:0] exp;
      logic [5:0] obs;
      bit         inv_ok;
      @(negedge clk);
      reset = rst; TA = ta; TB = tb; E = e; R = r;
      @(posedge clk);
      model_edge(rst, ta, tb, e, r);
      #1;
      obs = {verde, amarillo, rojo};
      exp = exp_q.pop_front();
      check(tag, obs, exp);
      inv_ok = 1'b1;
      for (int s = 0; s < 2; s++)
         if ((32'(verde[s]) + 32'(amarillo[s]) + 32'(rojo[s])) != 1) inv_ok = 1'b0;
      if ((verde[0] | amarillo[0]) && (verde[1] | amarillo[1])) inv_ok = 1'b0;
      check("invariant", {5'b0, inv_ok}, 6'd1);
   endtask

   initial begin
      // 1: reset, then hold A green while traffic on A
      step("reset0", 0, 1, 0, 0, 0);
      step("reset1", 0, 1, 0, 0, 0);
      check("reset_verde", {4'b0, verde}, 6'b000001);
      check("reset_rojo",  {4'b0, rojo},  6'b000010);
      for (int i = 0; i < 3; i++) step("a_hold", 1, 1, 1, 0, 0);
      // 2: A clears through two yellow cycles to B green
      for (int i = 0; i < 3; i++) step("a_to_b", 1, 0, 1, 0, 0);
      check("b_green_lit", {4'b0, verde}, 6'b000010);
      // 5: R has no effect outside emergency
      step("r_in_bgreen", 1, 0, 1, 0, 1);
      step("r_in_bgreen2", 1, 0, 1, 0, 0);
      // 3: B clears back to A
      for (int i = 0; i < 3; i++) step("b_to_a", 1, 1, 0, 0, 0);
      // 4: emergency mid-yellow, hold, E+R hold, resume
      step("a_yel", 1, 0, 0, 0, 0);
      step("emerg_mid_yel", 1, 0, 0, 1, 0);
      check("emerg_rojo", {4'b0, rojo}, 6'b000011);
      step("emerg_hold", 1, 0, 0, 0, 0);
      step("emerg_er", 1, 0, 0, 1, 1);
      step("emerg_resume", 1, 1, 0, 0, 1);
      // 6: reset during EMERG and during B_YELLOW
      step("emerg_again", 1, 1, 0, 1, 0);
      step("reset_in_emerg", 0, 1, 0, 1, 1);
      check("rst_emerg_verde", {4'b0, verde}, 6'b000001);
      for (int i = 0; i < 3; i++) step("go_b", 1, 0, 1, 0, 0);
      step("b_yel", 1, 0, 0, 0, 0);
      step("reset_in_byel", 0, 0, 0, 0, 0);
      check("rst_byel_verde", {4'b0, verde}, 6'b000001);
      // random traffic with occasional emergencies, resumes and resets
      for (int i = 0; i < 3000; i++) begin
         step("random",
              $urandom_range(0, 63) != 0,
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) == 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
